// File: rtl/key_ct_split.sv
// Splits a combined AXI-Stream frame into a key stream (first KEY_WORDS words) and a ciphertext stream.
// Optional status counters are enabled by defining KEY_CT_SPLIT_STATUS_EN.
module key_ct_split #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int KEY_WORDS  = 4
) (
  input  logic                  clk,
  input  logic                  reset,

  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_key_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_key_tkeep,
  output logic                  m_axis_key_tvalid,
  input  logic                  m_axis_key_tready,
  output logic                  m_axis_key_tlast,
  output logic                  m_axis_key_tuser,

  output logic [DATA_WIDTH-1:0] m_axis_ct_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_ct_tkeep,
  output logic                  m_axis_ct_tvalid,
  input  logic                  m_axis_ct_tready,
  output logic                  m_axis_ct_tlast,
  output logic                  m_axis_ct_tuser
`ifdef KEY_CT_SPLIT_STATUS_EN
  ,
  output logic [15:0]           frame_count,
  output logic [15:0]           short_frame_count,
  output logic                  short_frame_pulse
`endif
);

  localparam int                CNT_W    = $clog2(KEY_WORDS + 1);
  localparam logic [CNT_W-1:0]  KEY_LAST = CNT_W'(KEY_WORDS - 1);

  typedef enum logic {STATE_KEY, STATE_CT} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [KEEP_WIDTH-1:0] keep;
    logic                  last;
    logic                  user;
  } beat_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] key_cnt, key_cnt_next;
  logic             s_ready_q, s_ready_next;

  logic  accept, key_in_valid, ct_in_valid, key_cnt_end, short_frame;
  beat_t key_in, ct_in;

  beat_t key_out_q, key_tmp_q, ct_out_q, ct_tmp_q;
  logic  key_out_valid_q, key_tmp_valid_q, ct_out_valid_q, ct_tmp_valid_q;
  logic  key_out_load, ct_out_load, key_stall, ct_stall;

  assign s_axis_tready = s_ready_q;
  assign accept        = s_axis_tvalid && s_ready_q;
  assign key_in_valid  = accept && (state == STATE_KEY);
  assign ct_in_valid   = accept && (state == STATE_CT);
  assign key_cnt_end   = (key_cnt == KEY_LAST);
  assign short_frame   = key_in_valid && s_axis_tlast && !key_cnt_end;

  // Key tlast is generated from the word count; a premature input tlast marks a short frame as errored.
  assign key_in = {s_axis_tdata, s_axis_tkeep, key_cnt_end || s_axis_tlast,
                   s_axis_tuser || (s_axis_tlast && !key_cnt_end)};
  assign ct_in  = {s_axis_tdata, s_axis_tkeep, s_axis_tlast, s_axis_tuser};

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next   = state;
    key_cnt_next = key_cnt;
    case (state)
      STATE_KEY: begin
        if (key_in_valid) begin
          if (key_cnt_end || s_axis_tlast) begin
            key_cnt_next = '0;
            if (!s_axis_tlast) state_next = STATE_CT;
          end else begin
            key_cnt_next = key_cnt + 1'b1;
          end
        end
      end
      STATE_CT: begin
        if (ct_in_valid && s_axis_tlast) state_next = STATE_KEY;
      end
      default: state_next = STATE_KEY;
    endcase
  end

  // An output stage can take a new word when its register is empty or being drained this cycle.
  assign key_out_load = m_axis_key_tready || !key_out_valid_q;
  assign ct_out_load  = m_axis_ct_tready  || !ct_out_valid_q;
  assign key_stall    = key_out_valid_q && !m_axis_key_tready && key_in_valid;
  assign ct_stall     = ct_out_valid_q  && !m_axis_ct_tready  && ct_in_valid;

  // Ready looks only at the stage the next word will land in, so the other stream never blocks it.
  always_comb begin
    s_ready_next = 1'b0;
    if (state_next == STATE_KEY) s_ready_next = !key_tmp_valid_q && !key_stall;
    else                         s_ready_next = !ct_tmp_valid_q  && !ct_stall;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= STATE_KEY;
      key_cnt         <= '0;
      s_ready_q       <= 1'b0;
      key_out_valid_q <= 1'b0;
      key_tmp_valid_q <= 1'b0;
      ct_out_valid_q  <= 1'b0;
      ct_tmp_valid_q  <= 1'b0;
    end else begin
      state     <= state_next;
      key_cnt   <= key_cnt_next;
      s_ready_q <= s_ready_next;

      if (key_out_load) begin
        key_out_valid_q <= key_tmp_valid_q || key_in_valid;
        key_tmp_valid_q <= 1'b0;
      end else if (key_in_valid) begin
        key_tmp_valid_q <= 1'b1;
      end

      if (ct_out_load) begin
        ct_out_valid_q <= ct_tmp_valid_q || ct_in_valid;
        ct_tmp_valid_q <= 1'b0;
      end else if (ct_in_valid) begin
        ct_tmp_valid_q <= 1'b1;
      end
    end
  end

  // NOTE: payload registers carry no reset; their contents are ignored whenever the matching valid is low.
  always_ff @(posedge clk) begin
    if (key_out_load)      key_out_q <= key_tmp_valid_q ? key_tmp_q : key_in;
    else if (key_in_valid) key_tmp_q <= key_in;

    if (ct_out_load)       ct_out_q  <= ct_tmp_valid_q ? ct_tmp_q : ct_in;
    else if (ct_in_valid)  ct_tmp_q  <= ct_in;
  end

  assign m_axis_key_tdata  = key_out_q.data;
  assign m_axis_key_tkeep  = key_out_q.keep;
  assign m_axis_key_tlast  = key_out_q.last;
  assign m_axis_key_tuser  = key_out_q.user;
  assign m_axis_key_tvalid = key_out_valid_q;

  assign m_axis_ct_tdata   = ct_out_q.data;
  assign m_axis_ct_tkeep   = ct_out_q.keep;
  assign m_axis_ct_tlast   = ct_out_q.last;
  assign m_axis_ct_tuser   = ct_out_q.user;
  assign m_axis_ct_tvalid  = ct_out_valid_q;

`ifdef KEY_CT_SPLIT_STATUS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count       <= '0;
      short_frame_count <= '0;
      short_frame_pulse <= 1'b0;
    end else begin
      if (accept && s_axis_tlast) frame_count <= frame_count + 16'd1;
      if (short_frame) short_frame_count <= short_frame_count + 16'd1;
      short_frame_pulse <= short_frame;
    end
  end
`endif

endmodule

// File: tb/tb_key_ct_split.sv
// Scoreboard bench for key_ct_split: a frame-position model predicts each output word,
// independent monitors pop and compare whenever an output handshakes.
module tb_key_ct_split;

  localparam int DW        = 32;
  localparam int KW        = 4;
  localparam int KEY_WORDS = 4;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
    logic          user;
  } beat_t;

  logic          clk   = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic          s_tready;
  logic [DW-1:0] m_key_tdata, m_ct_tdata;
  logic [KW-1:0] m_key_tkeep, m_ct_tkeep;
  logic          m_key_tvalid, m_key_tlast, m_key_tuser;
  logic          m_ct_tvalid, m_ct_tlast, m_ct_tuser;
  logic          m_key_tready = 1'b1, m_ct_tready = 1'b1;
`ifdef KEY_CT_SPLIT_STATUS_EN
  logic [15:0]   frame_count, short_frame_count;
  logic          short_frame_pulse;
`endif

  key_ct_split #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .KEY_WORDS(KEY_WORDS)) dut (
    .clk               (clk),
    .reset             (reset),
    .s_axis_tdata      (s_tdata),
    .s_axis_tkeep      (s_tkeep),
    .s_axis_tvalid     (s_tvalid),
    .s_axis_tready     (s_tready),
    .s_axis_tlast      (s_tlast),
    .s_axis_tuser      (s_tuser),
    .m_axis_key_tdata  (m_key_tdata),
    .m_axis_key_tkeep  (m_key_tkeep),
    .m_axis_key_tvalid (m_key_tvalid),
    .m_axis_key_tready (m_key_tready),
    .m_axis_key_tlast  (m_key_tlast),
    .m_axis_key_tuser  (m_key_tuser),
    .m_axis_ct_tdata   (m_ct_tdata),
    .m_axis_ct_tkeep   (m_ct_tkeep),
    .m_axis_ct_tvalid  (m_ct_tvalid),
    .m_axis_ct_tready  (m_ct_tready),
    .m_axis_ct_tlast   (m_ct_tlast),
    .m_axis_ct_tuser   (m_ct_tuser)
`ifdef KEY_CT_SPLIT_STATUS_EN
    ,
    .frame_count       (frame_count),
    .short_frame_count (short_frame_count),
    .short_frame_pulse (short_frame_pulse)
`endif
  );

  always #5 clk = ~clk;

  int    n_vec = 0, n_miss = 0;
  beat_t key_q[$], ct_q[$];
  int    pos = 0, key_pops = 0, ct_pops = 0, ct_acc = 0, stall_cnt = 0;
  int    frames_m = 0, shorts_m = 0, pulses = 0;
  int    key_mode = 0, ct_mode = 0;   // 0: always ready, 1: random, 2: held low

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: a word's position in its frame alone decides where it goes and how it is flagged.
  always @(negedge clk) begin
    if (reset) begin
      key_q.delete();
      ct_q.delete();
      pos      = 0;
      frames_m = 0;
      shorts_m = 0;
      pulses   = 0;
    end else begin
      if (s_tvalid && s_tready) begin
        beat_t b;
        b.data = s_tdata;
        b.keep = s_tkeep;
        if (pos < KEY_WORDS) begin
          b.last = s_tlast || (pos == KEY_WORDS - 1);
          b.user = s_tuser || (s_tlast && pos < KEY_WORDS - 1);
          if (s_tlast && pos < KEY_WORDS - 1) shorts_m++;
          key_q.push_back(b);
        end else begin
          b.last = s_tlast;
          b.user = s_tuser;
          ct_q.push_back(b);
          ct_acc++;
        end
        if (s_tlast) frames_m++;
        pos = s_tlast ? 0 : pos + 1;
      end
      if (s_tvalid && !s_tready) stall_cnt++;
    end
  end

  // Output monitor: pops the expected word on every output handshake.
  always @(negedge clk) begin
    if (!reset) begin
      if (m_key_tvalid && m_key_tready) begin
        key_pops++;
        if (key_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL key_spurious: key word 0x%0h emitted, none expected", m_key_tdata);
        end else begin
          beat_t e;
          e = key_q.pop_front();
          check("key_beat", 64'({m_key_tdata, m_key_tkeep, m_key_tlast, m_key_tuser}), 64'(e));
        end
      end
      if (m_ct_tvalid && m_ct_tready) begin
        ct_pops++;
        if (ct_q.size() == 0) begin
          n_vec++; n_miss++;
          $display("FAIL ct_spurious: ct word 0x%0h emitted, none expected", m_ct_tdata);
        end else begin
          beat_t e;
          e = ct_q.pop_front();
          check("ct_beat", 64'({m_ct_tdata, m_ct_tkeep, m_ct_tlast, m_ct_tuser}), 64'(e));
        end
      end
`ifdef KEY_CT_SPLIT_STATUS_EN
      if (short_frame_pulse) pulses++;
`endif
    end
  end

  always @(posedge clk) begin
    #1;
    m_key_tready = (key_mode == 0) ? 1'b1 : (key_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    m_ct_tready  = (ct_mode == 0)  ? 1'b1 : (ct_mode == 1)  ? 1'($urandom_range(0, 1)) : 1'b0;
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic u);
    int n = 0;
    s_tdata = d; s_tkeep = k; s_tlast = l; s_tuser = u; s_tvalid = 1'b1;
    @(negedge clk);
    while (!s_tready && n < 1000) begin @(negedge clk); n++; end
    if (!s_tready) begin
      n_vec++; n_miss++;
      $display("FAIL send_timeout: s_axis_tready stayed 0, required 1 within 1000 cycles");
    end
    @(posedge clk); #1;
    s_tvalid = 1'b0;
  endtask

  task automatic send_frame(input int len, input logic [DW-1:0] base);
    for (int i = 0; i < len; i++) send(base + DW'(i), 4'hF, (i == len - 1), 1'b0);
  endtask

  task automatic do_reset(input int cycles);
    reset = 1'b1; s_tvalid = 1'b0;
    tick(cycles);
    check("rst_s_tready", 64'(s_tready), 64'd0);
    check("rst_key_valid", 64'(m_key_tvalid), 64'd0);
    check("rst_ct_valid", 64'(m_ct_tvalid), 64'd0);
    reset = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((key_q.size() != 0 || ct_q.size() != 0) && n < 3000) begin tick(1); n++; end
    tick(2);
    check({tag, "_drain"}, 64'(key_q.size() + ct_q.size()), 64'd0);
  endtask

`ifdef KEY_CT_SPLIT_STATUS_EN
  task automatic check_status(input string tag);
    check({tag, "_frame_count"}, 64'(frame_count), 64'(frames_m[15:0]));
    check({tag, "_short_count"}, 64'(short_frame_count), 64'(shorts_m[15:0]));
    check({tag, "_short_pulses"}, 64'(pulses), 64'(shorts_m));
  endtask
`endif

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int s0, kp, cp, a, n;

    do_reset(3);
    tick(2);

    // Normal frame: 4 key words then 8 ct words, no stalls expected.
    s0 = stall_cnt; kp = key_pops; cp = ct_pops;
    send(32'h1, 4'hF, 1'b0, 1'b0);
    check("key_latency", 64'(m_key_tvalid), 64'd1);
    check("key_first_data", 64'(m_key_tdata), 64'h1);
    for (int i = 2; i <= 4; i++) send(DW'(i), 4'hF, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send(32'hA0 + DW'(i), 4'hF, (i == 7), 1'b0);
    drain("normal");
    check("normal_no_stall", 64'(stall_cnt - s0), 64'd0);
    check("normal_key_words", 64'(key_pops - kp), 64'd4);
    check("normal_ct_words", 64'(ct_pops - cp), 64'd8);

    // Backpressure on the ct stream mid-frame.
    kp = key_pops; cp = ct_pops; a = ct_acc;
    fork
      send_frame(16, 32'h300);
      begin
        n = 0;
        while (ct_acc < a + 2 && n < 500) begin @(negedge clk); n++; end
        tick(1);
        ct_mode = 2;
        tick(1);
        a = ct_acc;
        tick(10);
        check("bp_accepts_le2", 64'((ct_acc - a) <= 2), 64'd1);
        check("bp_s_tready_low", 64'(s_tready), 64'd0);
        check("bp_ct_held", 64'(m_ct_tvalid), 64'd1);
        ct_mode = 0;
      end
    join
    drain("bp");
    check("bp_key_words", 64'(key_pops - kp), 64'd4);
    check("bp_ct_words", 64'(ct_pops - cp), 64'd12);

    // Short frame: two words with tlast on the second.
    kp = key_pops; cp = ct_pops;
    send(32'h11, 4'hF, 1'b0, 1'b0);
    send(32'h22, 4'hF, 1'b1, 1'b0);
    drain("short");
    check("short_key_words", 64'(key_pops - kp), 64'd2);
    check("short_ct_words", 64'(ct_pops - cp), 64'd0);
`ifdef KEY_CT_SPLIT_STATUS_EN
    check_status("short");
`endif

    // Back-to-back frames with no idle cycle.
    s0 = stall_cnt; kp = key_pops; cp = ct_pops;
    send_frame(12, 32'h100);
    send_frame(12, 32'h200);
    drain("b2b");
    check("b2b_no_stall", 64'(stall_cnt - s0), 64'd0);
    check("b2b_key_words", 64'(key_pops - kp), 64'd8);
    check("b2b_ct_words", 64'(ct_pops - cp), 64'd16);

    // Reset after two key words; the next frame must start counting keys afresh.
    send(32'h501, 4'hF, 1'b0, 1'b0);
    send(32'h502, 4'hF, 1'b0, 1'b0);
    do_reset(1);
    tick(2);
    kp = key_pops; cp = ct_pops;
    send_frame(12, 32'h600);
    drain("mid_rst");
    check("mid_rst_key_words", 64'(key_pops - kp), 64'd4);
    check("mid_rst_ct_words", 64'(ct_pops - cp), 64'd8);

    // Random valid/ready, random frame lengths including short and key-only frames.
    key_mode = 1; ct_mode = 1;
    for (int f = 0; f < 200; f++) begin
      int len;
      len = int'($urandom_range(1, 16));
      for (int i = 0; i < len; i++) begin
        tick(int'($urandom_range(0, 1)));
        send(DW'($urandom), KW'($urandom_range(0, 15)), (i == len - 1), ($urandom_range(0, 9) == 0));
      end
    end
    key_mode = 0; ct_mode = 0;
    drain("random");
`ifdef KEY_CT_SPLIT_STATUS_EN
    check_status("random");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/key_ct_split.md
Name: key_ct_split

Overview:
- Demultiplexer for the AES datapath. It takes one combined AXI-Stream frame and splits it into two streams.
- Frame layout: KEY_WORDS key words first, then ciphertext words up to tlast.
- Key words go to a key stream that ends with tlast on the final key word. Ciphertext words go to a ciphertext stream that keeps the input tlast.
- Sits upstream of the decrypt core and feeds its separate key and ciphertext AXI inputs.

Parameters:
- DATA_WIDTH, 32, tdata width of all streams.
- KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
- KEY_WORDS, 4, number of leading words routed to the key stream (range 1..8).

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- s_axis_tdata  input  DATA_WIDTH  combined frame data
- s_axis_tkeep  input  KEEP_WIDTH  byte enables
- s_axis_tvalid  input  1  data valid
- s_axis_tready  output  1  ready (registered)
- s_axis_tlast  input  1  end of frame
- s_axis_tuser  input  1  error/user flag
- m_axis_key_tdata/tkeep/tvalid/tlast/tuser  output  DATA_WIDTH/KEEP_WIDTH/1/1/1  key stream
- m_axis_key_tready  input  1  key stream ready
- m_axis_ct_tdata/tkeep/tvalid/tlast/tuser  output  DATA_WIDTH/KEEP_WIDTH/1/1/1  ciphertext stream
- m_axis_ct_tready  input  1  ciphertext stream ready

Behaviour:
- Reset (sampled on a clk edge with reset=1):
  - state=STATE_KEY, key_cnt=0.
  - s_axis_tready=0.
  - Both m_*_tvalid=0 and both temp valids=0.
  - data/keep/last/user registers are unreset; their values are don't-care while valid=0.
- Reset mid-frame discards the partial frame and all buffered words.
- FSM states:
  - STATE_KEY: accepted words go to the key stream.
    - key_cnt increments per accepted word.
    - On the word where key_cnt==KEY_WORDS-1: key tlast=1, key_cnt clears, go to STATE_CT.
    - If s_axis_tlast=1 on that same word (key-only frame): key tlast=1 and stay in STATE_KEY.
  - STATE_CT: accepted words go to the ciphertext stream with tlast/tuser forwarded. On s_axis_tlast=1, go to STATE_KEY.
- Short frame: s_axis_tlast=1 in STATE_KEY with key_cnt<KEY_WORDS-1.
  - The word is emitted on the key stream with tlast=1 and tuser forced to 1.
  - key_cnt clears; state stays STATE_KEY.
  - The ciphertext stream emits nothing for that frame.
- Key-stream tlast is generated internally; the input tlast is never forwarded as-is except on a short frame. Key tuser is input tuser OR short-frame.
- Output buffering: each output has a registered output stage plus a temp (skid) register.
  - Latency from input accept to output tvalid is 1 cycle.
  - Full throughput: 1 word/cycle when the destination tready is held at 1.
- s_axis_tready_reg next value is 1 when both hold:
  - the destination of the next word (decided by state_next) has its temp register empty, and
  - on that destination, not (output valid and tready low and input valid) is true.
  - It is 0 in the cycle following reset.
- Backpressure on one output never stalls words already queued for the other output. Input stalls only while its current destination is full.
- Simultaneous events:
  - The last key word and the first ct word can be accepted on consecutive cycles.
  - The key output may drain while ct fills, with no bubble.
- Transfers occur only on tvalid&&tready. Output tvalid never deasserts without a handshake. Output data is stable while tvalid=1 and tready=0.

Optional Feature:
- Macro KEY_CT_SPLIT_STATUS_EN.
- When defined, adds these outputs (reset to 0, wrapping at 2^16-1 -> 0):
  - frame_count (16-bit): increments on each accepted input tlast.
  - short_frame_count (16-bit): increments on each short frame.
  - short_frame_pulse (1-bit): single-cycle pulse in the cycle after a short-frame tlast is accepted.
- When undefined, these ports and counters are absent; datapath behaviour is identical.

Test Plan:
- Normal frame: send 0x00000001..0x00000004, then 0xA0..0xA7 (tlast on 0xA7), both tready=1 -> key stream 1,2,3,4 with tlast only on 4. Ct stream 0xA0..0xA7 with tlast on 0xA7, tkeep=0xF. Key valid 1 cycle after acceptance. No input stall.
- Backpressure: ct tready=0 for 10 cycles mid-frame -> s_axis_tready drops within 2 accepted ct words. Key words already buffered still complete. No data lost or duplicated when tready returns to 1.
- Short frame: 2 words 0x11,0x22 with tlast on 0x22 -> key stream 0x11, 0x22 (tlast=1, tuser=1). Ct stream empty. With KEY_CT_SPLIT_STATUS_EN: short_frame_count=1, frame_count=1.
- Back-to-back frames: two 12-word frames with no idle cycle -> 4+8 split each. Second frame's key words follow the first frame's ct tlast with zero bubble at input.
- Reset mid-frame: assert reset after 2 key words for 1 cycle -> all valids 0 and s_axis_tready=0 the next cycle. The next frame's first word goes to the key stream with key_cnt restarted at 0.
- Random valid/ready (both outputs, 50% toggle), 200 frames -> scoreboard matches in-order key/ct content, tlast and tuser.
